// File: rtl/operand_uart_rx.sv
// ---------------------------------------------------------------------------
// operand_uart_rx
//
// Serial front end of the signal processor. Receives 3-byte command frames
// (opcode, operand A, operand B) on an asynchronous UART line and presents
// them as parallel words for the logic/arithmetic units and op-select decoder.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Rx         in   asynchronous serial line, idle high
//   Resync     in   synchronous pulse; drops any partially received frame
//   Opcode     out  byte 0 of the last good frame
//   In1        out  byte 1 (operand A) of the last good frame
//   In2        out  byte 2 (operand B) of the last good frame
//   FrameValid out  one-cycle pulse when Opcode/In1/In2 update
//   FrameError out  one-cycle pulse on a bad stop bit (or parity error)
//   Busy       out  high while a frame is partially received
//
// Build option:
//   OPERAND_UART_RX_PARITY_EN  defined -> 8E1 with even-parity check,
//                              undefined -> plain 8N1.
// ---------------------------------------------------------------------------
module operand_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Rx,
    input  logic       Resync,
    output logic [7:0] Opcode,
    output logic [7:0] In1,
    output logic [7:0] In2,
    output logic       FrameValid,
    output logic       FrameError,
    output logic       Busy
);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

`ifdef OPERAND_UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, bit_nx;
    logic             rx_p0, rxs;
    logic [7:0]       shreg;
    logic [1:0]       idx;
    logic [7:0]       hold0, hold1;
    logic             hold_off;
    logic             shift_en;
    logic             stop_smp;
    logic             byte_ok;
    logic             frame_good;
    logic             frame_bad;

`ifdef OPERAND_UART_RX_PARITY_EN
    logic             par_smp;
    logic             par_bad;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    // Stage p0/p1: two-flop synchronizer; rxs is the only Rx view used below
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_p0 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_p0 <= Rx;
            rxs   <= rx_p0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        shift_en = 1'b0;
        stop_smp = 1'b0;
`ifdef OPERAND_UART_RX_PARITY_EN
        par_smp  = 1'b0;
`endif
        case (state)
            IDLE: begin
                // After a break the line must return high before re-arming
                if (!hold_off && !rxs) begin
                    state_nx = START;
                    cnt_nx   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else if (!rxs) begin
                    state_nx = DATA;
                    cnt_nx   = FULL_LOAD;
                    bit_nx   = 3'd0;
                end else begin
                    state_nx = IDLE;   // false start
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    shift_en = 1'b1;
                    cnt_nx   = FULL_LOAD;
                    if (bit_idx == 3'd7) begin
`ifdef OPERAND_UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end
            end
`ifdef OPERAND_UART_RX_PARITY_EN
            PARITY: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    par_smp  = 1'b1;
                    cnt_nx   = FULL_LOAD;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    stop_smp = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (Resync) state_nx = IDLE;
    end

    // A bad stop bit and a parity error collapse into one error event;
    // Resync suppresses both outcomes of the stop sample.
`ifdef OPERAND_UART_RX_PARITY_EN
    assign byte_ok = rxs && !par_bad;
`else
    assign byte_ok = rxs;
`endif
    assign frame_good = stop_smp && byte_ok && !Resync;
    assign frame_bad  = stop_smp && !byte_ok && !Resync;

    // Stage p2: byte assembly, frame hand-off and status strobes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            idx        <= 2'd0;
            hold0      <= 8'h00;
            hold1      <= 8'h00;
            hold_off   <= 1'b0;
            Opcode     <= 8'h00;
            In1        <= 8'h00;
            In2        <= 8'h00;
            FrameValid <= 1'b0;
            FrameError <= 1'b0;
`ifdef OPERAND_UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            cnt        <= cnt_nx;
            bit_idx    <= bit_nx;
            FrameValid <= frame_good && (idx == 2'd2);
            FrameError <= frame_bad;

            if (shift_en) shreg <= {rxs, shreg[7:1]};   // LSB first
`ifdef OPERAND_UART_RX_PARITY_EN
            if (par_smp) par_bad <= (rxs != even_parity(shreg));
`endif
            if (stop_smp && !rxs && !Resync) hold_off <= 1'b1;
            else if (state == IDLE && rxs)   hold_off <= 1'b0;

            if (Resync || frame_bad) begin
                idx <= 2'd0;
            end else if (frame_good) begin
                case (idx)
                    2'd0:    hold0 <= shreg;
                    2'd1:    hold1 <= shreg;
                    default: begin
                        // Byte 2 goes straight to the output register
                        Opcode <= hold0;
                        In1    <= hold1;
                        In2    <= shreg;
                    end
                endcase
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end

    assign Busy = (idx != 2'd0) || (state != IDLE);

endmodule

// File: tb/tb_operand_uart_rx.sv
module tb_operand_uart_rx;

    localparam int CPB = 4;

    logic       Clk     = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Rx      = 1'b1;
    logic       Resync  = 1'b0;
    logic [7:0] Opcode, In1, In2;
    logic       FrameValid, FrameError, Busy;

    operand_uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Rx(Rx), .Resync(Resync),
        .Opcode(Opcode), .In1(In1), .In2(In2),
        .FrameValid(FrameValid), .FrameError(FrameError), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Observed events
    int fv_cnt = 0, fe_cnt = 0, fv_cyc = 0;
    bit both_seen = 1'b0;
    always @(negedge Clk) begin
        if (FrameValid) begin
            fv_cnt++;
            fv_cyc = cyc;
        end
        if (FrameError) fe_cnt++;
        if (FrameValid && FrameError) both_seen = 1'b1;
    end

    // Reference model: frame-level view of what has been sent
    logic [7:0] m_part [3];
    int         m_cnt = 0, m_fv = 0, m_fe = 0;
    logic [7:0] m_op = 8'h00, m_in1 = 8'h00, m_in2 = 8'h00;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge Clk); #1;
        Rx = b;
        repeat (CPB - 1) @(posedge Clk);
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".fv"},   fv_cnt, m_fv);
        check({tag, ".fe"},   fe_cnt, m_fe);
        check({tag, ".out"},  {8'h00, Opcode, In1, In2}, {8'h00, m_op, m_in1, m_in2});
        check({tag, ".busy"}, Busy, (m_cnt != 0));
    endtask

    // Sends one byte; stop_ok=0 gives a break in the stop slot, par_ok=0 flips
    // the parity bit (parity builds only), rs_at_stop pulses Resync on the
    // cycle of the mid-stop sample.
    task automatic send_byte(input logic [7:0] d, input bit stop_ok,
                             input bit par_ok, input bit rs_at_stop);
        int  sc;
        bit  perr;
        bit  done_frame;
        done_frame = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef OPERAND_UART_RX_PARITY_EN
        drive_bit((^d) ^ !par_ok);
        perr = !par_ok;
`else
        perr = 1'b0;
`endif
        @(posedge Clk); #1;
        Rx = stop_ok;
        sc = cyc;
        repeat (3) @(posedge Clk);
        @(posedge Clk); #1;
        Rx = 1'b1;
        if (rs_at_stop) Resync = 1'b1;
        @(posedge Clk); #1;
        Resync = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        if (rs_at_stop) begin
            m_cnt = 0;
        end else if (!stop_ok || perr) begin
            m_fe++;
            m_cnt = 0;
        end else begin
            m_part[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 3) begin
                m_op  = m_part[0];
                m_in1 = m_part[1];
                m_in2 = m_part[2];
                m_fv++;
                m_cnt = 0;
                done_frame = 1'b1;
            end
        end
        compare_state("byte");
        // Sync (2) + half bit (2) + one cycle to the registered strobe = 5
        if (done_frame) check("fv_latency", fv_cyc - sc, 5);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1, 1'b1, 1'b0);
        send_byte(b, 1'b1, 1'b1, 1'b0);
        send_byte(c, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic pulse_resync();
        @(posedge Clk); #1;
        Resync = 1'b1;
        @(posedge Clk); #1;
        Resync = 1'b0;
        m_cnt = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("resync.busy", Busy, 1'b0);
        check("resync.fe", fe_cnt, m_fe);
    endtask

    initial begin
        // Reset, then a quiet line
        repeat (3) @(posedge Clk);
        #1;
        check("reset.out", {FrameValid, FrameError, Busy, Opcode, In1, In2}, '0);
        Reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            check("idle", {FrameValid, FrameError, Busy, Opcode, In1, In2}, '0);
        end

        // Basic frame
        send_frame(8'h03, 8'hA5, 8'h3C);

        // Bad stop bit on byte 2, then recovery
        send_byte(8'h01, 1'b1, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b1, 1'b0);
        send_byte(8'h0F, 1'b0, 1'b1, 1'b0);
        send_frame(8'h02, 8'h11, 8'h22);

        // One-cycle low glitch on an idle line
        @(posedge Clk); #1;
        Rx = 1'b0;
        @(posedge Clk); #1;
        Rx = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        compare_state("glitch");

        // Resync between bytes
        send_byte(8'h05, 1'b1, 1'b1, 1'b0);
        send_byte(8'h77, 1'b1, 1'b1, 1'b0);
        pulse_resync();
        send_frame(8'h06, 8'h12, 8'h34);

        // Resync on the very stop sample of byte 2
        send_byte(8'h09, 1'b1, 1'b1, 1'b0);
        send_byte(8'h0A, 1'b1, 1'b1, 1'b0);
        send_byte(8'h0B, 1'b1, 1'b1, 1'b1);
        send_frame(8'h0C, 8'h0D, 8'h0E);

        // Reset in the middle of byte 1
        send_byte(8'h55, 1'b1, 1'b1, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        Rx = 1'b1;
        #1;
        m_op = 8'h00; m_in1 = 8'h00; m_in2 = 8'h00; m_cnt = 0;
        check("midreset.out", {Busy, Opcode, In1, In2}, '0);
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        send_frame(8'h07, 8'h80, 8'h01);

`ifdef OPERAND_UART_RX_PARITY_EN
        send_byte(8'h10, 1'b1, 1'b1, 1'b0);
        send_byte(8'h20, 1'b1, 1'b0, 1'b0);
        send_frame(8'h31, 8'h32, 8'h33);
`endif

        // Randomized frames with occasional bad stops and resyncs
        for (int f = 0; f < 12; f++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 15) == 0) pulse_resync();
                send_byte(8'($urandom_range(0, 255)),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 9) != 0), 1'b0);
            end
        end

        check("fv_fe_exclusive", both_seen, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
